main_control_fsm: RTL and testbench

Multicycle main control unit for the RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback states from the 7-bit opcode held in the instruction register. It drives the datapath enables and mux selects, plus the 2-bit `alu_op` consumed by `alu_control`. It supports lw, sw, beq and R-type, handles a ready-based memory handshake, and traps unknown opcodes.

---
 rtl/riscv_ctrl_pkg.sv | 38 +++
 rtl/main_control_fsm.sv | 144 ++++++++++++++
 tb/tb_main_control_fsm.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V main control unit and alu_control.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTER = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BEQ      = 4'd8,
        ST_ILLEGAL  = 4'd9
    } ctrl_state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle main control: sequences fetch/decode/execute/memory/writeback
// from the IR opcode and drives datapath enables, selects and alu_op.
module main_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_instr
);

    ctrl_state_t state, state_next;
    logic        pc_update;
    logic        branch;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_next;
    end

    // Next-state and Moore output decode; mem_ready/zero only gate strobes.
    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        pc_write      = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = ST_MEMADR;
                    OP_R:         state_next = ST_EXECUTER;
                    OP_BEQ:       state_next = ST_BEQ;
                    default:      state_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW:   state_next = ST_MEMREAD;
                    OP_SW:   state_next = ST_MEMWRITE;
                    default: state_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEMWRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_EXECUTER: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_FUNCT;
                state_next = ST_ALUWB;
            end
            ST_ALUWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_src_b  = SRCB_RD2;
                alu_op     = ALUOP_SUB;
                branch     = 1'b1;
                instr_done = 1'b1;
                state_next = ST_FETCH;
            end
            ST_ILLEGAL: begin
                illegal_instr = 1'b1;
            end
            default: state_next = ST_ILLEGAL;
        endcase

        pc_write = pc_update | (branch & zero);

        // Reset gates every output, so nothing is requested while held.
        if (!rst_n) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            result_src    = 2'b00;
            alu_op        = 2'b00;
            instr_done    = 1'b0;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// output vectors (one entry per cycle, waits included) and replayed against the DUT.
module tb_main_control_fsm;

    logic       clk, rst_n, zero, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       instr_done, illegal_instr;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           BQ = 7'b1100011, BAD = 7'b0010011;

    typedef struct {
        int         ph;
        logic [6:0] op;
        logic       rdy;
        logic       z;
        logic [15:0] e;
    } cyc_t;

    cyc_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    string ph_name[10] = '{"fetch", "decode", "memadr", "memread", "memwb",
                           "memwrite", "exec", "aluwb", "beq", "trap"};

    function automatic logic [15:0] obs();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, instr_done, illegal_instr};
    endfunction

    // {mem_req,mem_write,adr_src,ir_write,pc_write,reg_write,a,b,res,aluop,done,ill}
    function automatic logic [15:0] v(input logic mrq, mw, adr, irw, pcw, rw,
                                      input logic [1:0] a, b, r, op,
                                      input logic done, ill);
        return {mrq, mw, adr, irw, pcw, rw, a, b, r, op, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        n_vec++;
        if (o !== e) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic push(input int ph, input logic [6:0] op, input logic rdy,
                        input logic z, input logic [15:0] e);
        cyc_t c;
        c.ph = ph; c.op = op; c.rdy = rdy; c.z = z; c.e = e;
        q.push_back(c);
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Expected cycle trace of one instruction from the behaviour table.
    task automatic plan(input logic [6:0] op, input int fw, input int mw, input logic zb);
        for (int i = 0; i < fw; i++)
            push(0, op, 1'b0, rb(), v(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 0,0));
        push(0, op, 1'b1, rb(), v(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 0,0));
        push(1, op, rb(), rb(), v(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0,0));
        case (op)
            LW: begin
                push(2, op, rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0));
                for (int i = 0; i < mw; i++)
                    push(3, op, 1'b0, rb(), v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
                push(3, op, 1'b1, rb(), v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
                push(4, op, rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 1,0));
            end
            SW: begin
                push(2, op, rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0,0));
                for (int i = 0; i < mw; i++)
                    push(5, op, 1'b0, rb(), v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
                push(5, op, 1'b1, rb(), v(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,0));
            end
            RT: begin
                push(6, op, rb(), rb(), v(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 0,0));
                push(7, op, rb(), rb(), v(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1,0));
            end
            BQ:
                push(8, op, rb(), zb, v(0,0,0,0,zb,0, 2'b10,2'b00,2'b00,2'b01, 1,0));
            default:
                for (int i = 0; i < 20; i++)
                    push(9, op, rb(), rb(), v(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,1));
        endcase
    endtask

    // Replay up to n queued cycles; inputs set 1 time unit after posedge,
    // outputs sampled on the falling edge.
    task automatic run(input int n);
        cyc_t c;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            c = q.pop_front();
            opcode = c.op; mem_ready = c.rdy; zero = c.z;
            @(negedge clk);
            chk(ph_name[c.ph], obs(), c.e);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = LW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("in_reset", obs(), 16'h0000);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] ops[4] = '{LW, SW, RT, BQ};

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = LW;
        @(posedge clk); #1;
        do_reset();

        // Directed: zero-wait lw, R with 2 fetch waits, sw with 4 store waits, beq both ways.
        plan(LW, 0, 0, 1'b0);
        plan(RT, 2, 0, 1'b0);
        plan(SW, 0, 4, 1'b0);
        plan(BQ, 0, 0, 1'b1);
        plan(BQ, 1, 0, 1'b0);
        run(1000);

        // Random mix with random wait states.
        for (int k = 0; k < 60; k++) begin
            plan(ops[$urandom_range(0, 3)], $urandom_range(0, 3), $urandom_range(0, 3), rb());
            run(1000);
        end

        // Reset in the middle of a stalled load read: request must drop at once.
        plan(LW, 0, 3, 1'b0);
        run(4);
        opcode = LW; mem_ready = 1'b0;
        #2 chk("pre_abort", obs(), v(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0));
        rst_n = 1'b0;
        #1 chk("abort", obs(), 16'h0000);
        q.delete();
        @(posedge clk); #1;
        do_reset();
        plan(RT, 0, 0, 1'b0);
        run(1000);

        // Unknown opcode traps until reset, then fetch resumes.
        plan(BAD, 1, 0, 1'b0);
        run(1000);
        do_reset();
        plan(BQ, 0, 0, 1'b1);
        plan(LW, 1, 1, 1'b0);
        run(1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
